// File: rtl/param_bit_tx_if.sv
// param_bit_tx_if: valid/ready bit-stream handshake between a transmitter and a sink.
//   valid    : master -> slave, data_bit/bit_idx/last are meaningful
//   ready    : slave -> master, sink accepts the beat when valid && ready
//   data_bit : master -> slave, current pattern bit
//   bit_idx  : master -> slave, index of the current bit (IW bits)
//   last     : master -> slave, final bit of the final pass
interface param_bit_tx_if #(
    parameter int unsigned IW = 1
) ();
    logic          valid;
    logic          ready;
    logic          data_bit;
    logic [IW-1:0] bit_idx;
    logic          last;

    modport master (
        output valid,
        output data_bit,
        output bit_idx,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data_bit,
        input  bit_idx,
        input  last,
        output ready
    );
endinterface

// File: rtl/param_bit_tx.sv
// param_bit_tx: serialises a constant WIDTH-bit PATTERN (bit 0 first) REPEAT times per start.
//   clk   : clock, all state updates on posedge
//   rst_n : asynchronous active-low reset
//   start : single-cycle request, sampled only in IDLE
//   busy  : high while sending
//   done  : one-cycle pulse after the final bit is accepted
//   tx    : master side of the valid/ready bit stream (valid, ready, data_bit, bit_idx, last)
module param_bit_tx #(
    parameter int unsigned       WIDTH   = 1,
    parameter logic [WIDTH-1:0]  PATTERN = '0,
    parameter int unsigned       REPEAT  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           busy,
    output logic           done,
    param_bit_tx_if.master tx
);
    localparam int unsigned IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PAT_W = 1 << IW;

    // Pattern zero-padded to 2**IW bits so any bit_idx value is an in-range select.
    localparam logic [PAT_W-1:0] PAT_EXT  = PAT_W'(PATTERN);
    localparam logic [IW-1:0]    IDX_MAX  = IW'(WIDTH - 1);
    localparam logic [7:0]       PASS_MAX = 8'(REPEAT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("param_bit_tx: WIDTH %0d outside 1..64", WIDTH);
    end
    if (REPEAT < 1 || REPEAT > 255) begin : g_bad_repeat
        $error("param_bit_tx: REPEAT %0d outside 1..255", REPEAT);
    end

    logic [1:0]    state_q,   state_d;
    logic [IW-1:0] bit_idx_q, bit_idx_d;
    logic [7:0]    pass_q,    pass_d;
    logic          at_last;

    assign at_last = (state_q == ST_SEND) && (bit_idx_q == IDX_MAX) && (pass_q == PASS_MAX);

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        pass_d    = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SEND;
                    bit_idx_d = '0;
                    pass_d    = '0;
                end
            end
            ST_SEND: begin
                if (tx.ready) begin
                    if (at_last) begin
                        // Counters are cleared on completion rather than stepped,
                        // so the pass counter never reaches REPEAT.
                        state_d   = ST_DONE;
                        bit_idx_d = '0;
                        pass_d    = '0;
                    end else if (bit_idx_q == IDX_MAX) begin
                        bit_idx_d = '0;
                        pass_d    = pass_q + 8'd1;
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            pass_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            pass_q    <= pass_d;
        end
    end

    // All outputs decode registered state, so reset forces them immediately.
    assign tx.valid    = (state_q == ST_SEND);
    assign tx.data_bit = PAT_EXT[bit_idx_q];
    assign tx.bit_idx  = bit_idx_q;
    assign tx.last     = at_last;
    assign busy        = (state_q == ST_SEND);
    assign done        = (state_q == ST_DONE);
endmodule

// File: tb/tb_param_bit_tx.sv
module tb_param_bit_tx;
    typedef struct packed {
        logic       bit_v;
        logic [5:0] idx;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start_r [3];
    logic ready_r [3];
    logic valid_w [3];
    logic data_w  [3];
    logic last_w  [3];
    logic busy_w  [3];
    logic done_w  [3];
    logic [5:0] idx_w [3];

    int checks = 0;
    int errors = 0;
    int done_cnt [3] = '{0, 0, 0};
    int done_exp [3] = '{0, 0, 0};
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];

    // Reset value of data_bit (PATTERN[0]) and beats per transfer for each instance.
    localparam int P0 [3] = '{0, 0, 1};
    localparam int NB [3] = '{1, 4, 6};

    always #5 clk = ~clk;

    param_bit_tx_if #(.IW(1)) if0 ();
    param_bit_tx_if #(.IW(2)) if1 ();
    param_bit_tx_if #(.IW(2)) if2 ();

    param_bit_tx #(.WIDTH(1), .PATTERN(1'b0), .REPEAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_r[0]),
        .busy(busy_w[0]), .done(done_w[0]), .tx(if0.master));
    param_bit_tx #(.WIDTH(4), .PATTERN(4'b1010), .REPEAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_r[1]),
        .busy(busy_w[1]), .done(done_w[1]), .tx(if1.master));
    param_bit_tx #(.WIDTH(3), .PATTERN(3'b011), .REPEAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_r[2]),
        .busy(busy_w[2]), .done(done_w[2]), .tx(if2.master));

    assign if0.ready = ready_r[0];
    assign if1.ready = ready_r[1];
    assign if2.ready = ready_r[2];
    assign valid_w[0] = if0.valid;
    assign valid_w[1] = if1.valid;
    assign valid_w[2] = if2.valid;
    assign data_w[0]  = if0.data_bit;
    assign data_w[1]  = if1.data_bit;
    assign data_w[2]  = if2.data_bit;
    assign last_w[0]  = if0.last;
    assign last_w[1]  = if1.last;
    assign last_w[2]  = if2.last;
    assign idx_w[0]   = 6'(if0.bit_idx);
    assign idx_w[1]   = 6'(if1.bit_idx);
    assign idx_w[2]   = 6'(if2.bit_idx);

    task automatic chk(input int k, input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL dut%0d %s got %0d expected %0d", k, name, got, exp);
        end
    endtask

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qfront(input int k);
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic void qpop(input int k);
        case (k)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endfunction

    function automatic void qpush(input int k, input logic b, input int idx, input logic l);
        exp_t e;
        e.bit_v = b;
        e.idx   = 6'(idx);
        e.last  = l;
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic void qclear(input int k);
        case (k)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endfunction

    // Hand-computed beat sequences: (data_bit, bit_idx, last).
    function automatic void push_exp(input int k);
        case (k)
            0: qpush(0, 1'b0, 0, 1'b1);
            1: begin
                qpush(1, 1'b0, 0, 1'b0);
                qpush(1, 1'b1, 1, 1'b0);
                qpush(1, 1'b0, 2, 1'b0);
                qpush(1, 1'b1, 3, 1'b1);
            end
            default: begin
                qpush(2, 1'b1, 0, 1'b0);
                qpush(2, 1'b1, 1, 1'b0);
                qpush(2, 1'b0, 2, 1'b0);
                qpush(2, 1'b1, 0, 1'b0);
                qpush(2, 1'b1, 1, 1'b0);
                qpush(2, 1'b0, 2, 1'b1);
            end
        endcase
    endfunction

    task automatic check_reset(input int k);
        chk(k, "rst_valid", int'(valid_w[k]), 0);
        chk(k, "rst_data_bit", int'(data_w[k]), P0[k]);
        chk(k, "rst_bit_idx", int'(idx_w[k]), 0);
        chk(k, "rst_last", int'(last_w[k]), 0);
        chk(k, "rst_busy", int'(busy_w[k]), 0);
        chk(k, "rst_done", int'(done_w[k]), 0);
    endtask

    // Scoreboard monitor: every presented beat must match the queue head; pop on acceptance.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (valid_w[k]) begin
                if (qsize(k) == 0) begin
                    chk(k, "unexpected_valid", 1, 0);
                end else begin
                    e = qfront(k);
                    chk(k, "data_bit", int'(data_w[k]), int'(e.bit_v));
                    chk(k, "bit_idx", int'(idx_w[k]), int'(e.idx));
                    chk(k, "last", int'(last_w[k]), int'(e.last));
                    if (ready_r[k]) qpop(k);
                end
            end
            if (done_w[k]) begin
                done_cnt[k]++;
                chk(k, "done_count", done_cnt[k], done_exp[k]);
            end
        end
    end

    task automatic do_abort(input int k);
        rst_n = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) check_reset(j);
        qclear(k);
        ready_r[k] = 1'b1;
        @(posedge clk); #1;
        check_reset(k);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk(k, "abort_no_done", int'(done_w[k]), 0);
        end
    endtask

    task automatic run(input int k, input int stall_pos, input int stall_n,
                       input int abort_at, input bit repulse);
        int pos = 0;
        int cyc = 0;
        int stalled = 0;
        logic v;
        push_exp(k);
        if (abort_at < 0) done_exp[k]++;
        start_r[k] = 1'b1;
        @(posedge clk); #1;
        start_r[k] = 1'b0;
        chk(k, "first_valid", int'(valid_w[k]), 1);
        chk(k, "busy", int'(busy_w[k]), 1);
        while (!done_w[k] && cyc < 200) begin
            if (abort_at >= 0 && pos == abort_at) begin
                do_abort(k);
                return;
            end
            ready_r[k] = !(pos == stall_pos && stalled < stall_n);
            if (!ready_r[k]) stalled++;
            start_r[k] = repulse && (cyc == 1);
            v = valid_w[k];
            @(posedge clk); #1;
            cyc++;
            if (v && ready_r[k]) pos++;
        end
        start_r[k] = 1'b0;
        ready_r[k] = 1'b1;
        chk(k, "latency", cyc, NB[k] + stall_n);
        chk(k, "beats", pos, NB[k]);
        chk(k, "done_valid_low", int'(valid_w[k]), 0);
        chk(k, "done_busy_low", int'(busy_w[k]), 0);
        if (repulse) start_r[k] = 1'b1;
        @(posedge clk); #1;
        start_r[k] = 1'b0;
        chk(k, "done_one_cycle", int'(done_w[k]), 0);
        chk(k, "idle_valid", int'(valid_w[k]), 0);
        @(posedge clk); #1;
        chk(k, "idle_busy", int'(busy_w[k]), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout global time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start_r[k] = 1'b0;
            ready_r[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_reset(k);
        @(negedge clk);
        rst_n = 1'b1;
        // Start presented right after release: must be taken on the first posedge.
        run(0, -1, 0, -1, 1'b0);
        run(1, -1, 0, -1, 1'b0);
        run(1, 2, 3, -1, 1'b0);
        run(2, -1, 0, -1, 1'b0);
        run(1, -1, 0, 2, 1'b0);
        run(1, -1, 0, -1, 1'b0);
        run(2, -1, 0, -1, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk(k, "done_total", done_cnt[k], done_exp[k]);
            chk(k, "queue_empty", qsize(k), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/param_bit_tx.md
PARAM_BIT_TX -- requirements
Module: param_bit_tx

Interface
REQ-001 Parameter: WIDTH, default 1, pattern length in bits; legal range 1..64; WIDTH=1 SHALL be treated as a 1-bit vector, so that PATTERN[0] is a legal select.
REQ-002 Parameter: PATTERN, default 1'b0, constant of WIDTH bits to transmit; bit 0 is sent first.
REQ-003 Parameter: REPEAT, default 1, number of full pattern passes per start; legal range 1..255.
REQ-004 Port: clk  input  1  sole clock; all state SHALL update on its posedge.
REQ-005 Port: rst_n  input  1  reset, asynchronous assert, active-low; synchronous release to clk is the integrator's responsibility.
REQ-006 Port: start  input  1  single-cycle request to begin a transmission.
REQ-007 Port: ready  input  1  sink accepts data_bit when ready && valid.
REQ-008 Port: valid  output  1  data_bit and bit_idx are meaningful.
REQ-009 Port: data_bit  output  1  current pattern bit, PATTERN[bit_idx].
REQ-010 Port: bit_idx  output  IW  index of the current bit; IW = max(1, clog2(WIDTH)).
REQ-011 Port: last  output  1  high with valid on the final bit of the final pass.
REQ-012 Port: busy  output  1  high in SEND.
REQ-013 Port: done  output  1  one-cycle pulse after the final bit is accepted.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SEND and DONE.
REQ-015 IDLE to SEND SHALL occur on the first posedge with start=1; bit_idx=0 and pass counter=0 load on the same edge.
REQ-016 In SEND, valid SHALL be 1 and data_bit SHALL equal PATTERN[bit_idx] combinationally from registered bit_idx.
REQ-017 On a posedge with valid && ready, bit_idx SHALL increment; when bit_idx==WIDTH-1, it SHALL wrap to 0 and the pass counter SHALL increment.
REQ-018 With ready=0, valid, data_bit, bit_idx and last SHALL hold unchanged; valid SHALL never drop without acceptance.
REQ-019 last SHALL be 1 when bit_idx==WIDTH-1 and pass counter==REPEAT-1, and 0 otherwise.
REQ-020 Acceptance with last=1 SHALL move SEND to DONE; valid SHALL be 0 the next cycle.
REQ-021 DONE SHALL assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-022 start SHALL be ignored in SEND and DONE; it SHALL not queue.
REQ-023 In IDLE, start is sampled; a start in the DONE cycle SHALL be dropped.
REQ-024 With WIDTH=1, bit_idx SHALL stay 0; each acceptance completes one pass.
REQ-025 Latency: the first valid SHALL appear 1 cycle after the start edge. Minimum total start-to-done time with ready held high SHALL be WIDTH*REPEAT+1 cycles.
REQ-026 Counters SHALL not overflow: the pass counter is 8 bits and bit_idx is IW bits; no index SHALL exceed WIDTH-1.
REQ-027 WIDTH outside 1..64 or REPEAT outside 1..255 SHALL be rejected by an elaboration-time check ($error).

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, valid=0, data_bit=PATTERN[0], bit_idx=0, last=0, busy=0, done=0 and pass counter=0.
REQ-029 A reset asserted mid-SEND SHALL abort the transmission; no done pulse SHALL be issued for the aborted transfer.
REQ-030 The first start SHALL be accepted on the first posedge after rst_n rises.

Verification
REQ-031 WIDTH=1, PATTERN=1'b0, ready=1, start pulse -> next cycle valid=1, data_bit=0, bit_idx=0, last=1; following cycle done=1; then IDLE.
REQ-032 WIDTH=4, PATTERN=4'b1010, ready=1 -> data_bit 0,1,0,1 on consecutive cycles; last only on the 4th; done 5 cycles after start.
REQ-033 WIDTH=4, PATTERN=4'b1010, ready low for 3 cycles on bit 2 -> valid, data_bit=0 and bit_idx=2 held for 3 cycles; sequence otherwise unchanged.
REQ-034 WIDTH=3, PATTERN=3'b011, REPEAT=2 -> 1,1,0,1,1,0; bit_idx wraps 2 to 0; last only on the 6th bit.
REQ-035 Reset pulse after 2 accepted bits -> all outputs at reset values while rst_n=0; no done; the next start restarts at bit_idx=0.
REQ-036 start re-pulsed during SEND and in the DONE cycle -> ignored; exactly one done per accepted start.
